ysyx_22050710_mem_responder: RTL and testbench
==============================================

// Module: ysyx_22050710_mem_responder
// PURPOSE
//  Memory-side responder for the NPC core's load/store/fetch requests. Accepts one request
//  at a time over a valid/ready channel and returns a 64-bit response after LATENCY cycles.
//  Holds the response until the core takes it. Backed by an internal doubleword array.
//  Replaces zero-latency DPI memory for multi-cycle core bring-up.
// PARAMETERS
//  BASE     64'h8000_0000  byte address of word 0
//  DEPTH    1024           number of 64-bit words (power of two)
//  LATENCY  1              cycles from request accept to o_resp_valid; legal range 1..15
// PORTS
//  i_clk        in   1   clock, rising edge
//  i_rst        in   1   reset, asynchronous, active-high
//  i_req_valid  in   1   request present
//  o_req_ready  out  1   responder can accept a request
//  i_req_addr   in   64  byte address; bits [2:0] ignored
//  i_req_wen    in   1   1 = write, 0 = read
//  i_req_wdata  in   64  write data, doubleword-aligned lanes
//  i_req_wmask  in   8   byte strobes; bit n enables wdata[8n+7:8n]
//  o_resp_valid out  1   response present
//  i_resp_ready in   1   core accepts response
//  o_resp_rdata out  64  read doubleword; 0 for write responses
//  o_resp_err   out  1   access error (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; o_req_ready=1, o_resp_valid=0, o_resp_rdata=0,
//   o_resp_err=0; latency counter=0. Array contents are not reset. Any in-flight request is
//   discarded with no response. A write already accepted stays committed.
//  Index = (i_req_addr - BASE) >> 3, low log2(DEPTH) bits.
//  FSM:
//   IDLE: o_req_ready=1. Accept on i_req_valid&&o_req_ready. Latch addr, wen, and err flag.
//     A write commits its masked bytes on the accept edge. Load cnt=LATENCY-1.
//     Next state: LATENCY==1 -> RESP; otherwise WAIT.
//   WAIT: o_req_ready=0. cnt decrements each cycle. At cnt==1 -> RESP.
//   RESP: o_resp_valid=1. o_resp_rdata = array[index] sampled on the edge entering RESP
//     (0 for writes). Data and err stay stable while valid&&!ready.
//     On i_resp_ready: o_resp_valid drops next cycle and FSM -> IDLE.
//     No new request is accepted in the same cycle.
//  Accept-to-valid latency is exactly LATENCY edges. Minimum issue interval is LATENCY+1 cycles.
//  Read after write: a write fully completes before the next accept, so a read always sees it.
//  wmask=0 write: no bytes change; a response is still returned.
//  i_req_valid while o_req_ready=0: ignored. The requester must hold it until accepted.
//  i_resp_ready outside RESP: ignored.
// CONFIGURATION
//  NPC_MEMRESP_BOUNDS_EN defined:
//   Address outside [BASE, BASE+DEPTH*8) sets o_resp_err=1. The write is dropped;
//   o_resp_rdata=0. Timing is unchanged.
//  NPC_MEMRESP_BOUNDS_EN undefined:
//   o_resp_err tied 0. Out-of-range addresses alias modulo DEPTH words.
// TESTING (BASE=0x8000_0000, DEPTH=1024, LATENCY=2 unless noted)
//  1. Write addr 0x8000_0010, data 0x1122334455667788, mask 0xFF; read same addr
//     -> read response 0x1122334455667788. Valid exactly 2 cycles after each accept.
//  2. Write mask 0x0F, data 0xFFFF_FFFF_AAAA_BBBB over test-1 word
//     -> read returns 0x11223344AAAABBBB.
//  3. Read with i_resp_ready=0 for 5 cycles -> o_resp_valid and rdata stay stable;
//     o_req_ready=0 throughout; a held i_req_valid is not accepted until the cycle after handshake.
//  4. Assert i_rst while in WAIT -> next cycle o_req_ready=1, o_resp_valid=0,
//     and no stale response appears afterward.
//  5. BOUNDS_EN, read 0x7FFF_FFF8 -> o_resp_err=1, rdata=0. Write to 0x8000_2000 then read
//     0x8000_0000 -> word 0 unchanged.
//     Without BOUNDS_EN, the same write aliases to word 0.
//  6. LATENCY=1, back-to-back reads with i_resp_ready held 1 -> a response every 2 cycles.

Source files
------------

// File: rtl/ysyx_22050710_mem_responder.sv
// ysyx_22050710_mem_responder
//   Memory-side responder for the NPC core. One request at a time over a
//   valid/ready channel; the 64-bit response appears LATENCY cycles after the
//   accept cycle and is held until the core takes it. Storage is an internal
//   doubleword array that is never cleared by reset.
//
//   Optional build macro: NPC_MEMRESP_BOUNDS_EN
//     defined   : addresses outside [BASE, BASE+DEPTH*8) raise o_resp_err, the
//                 write is dropped and the read data is forced to zero.
//     undefined : o_resp_err is always zero and out-of-range addresses alias
//                 modulo DEPTH words.
module ysyx_22050710_mem_responder #(
   parameter logic [63:0] BASE    = 64'h8000_0000,
   parameter int          DEPTH   = 1024,
   parameter int          LATENCY = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [63:0] i_req_addr,
   input  logic        i_req_wen,
   input  logic [63:0] i_req_wdata,
   input  logic [7:0]  i_req_wmask,
   output logic        o_resp_valid,
   input  logic        i_resp_ready,
   output logic [63:0] o_resp_rdata,
   output logic        o_resp_err
);

   localparam int          IDX_W    = $clog2(DEPTH);
   localparam logic [63:0] SPAN     = 64'(DEPTH) << 3;
   // Counter preload; the counter is 4 bits wide because LATENCY tops out at 15.
   localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
   localparam logic        LAT_ONE  = (LATENCY == 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Byte-lane merge: lanes whose strobe is set take the new data.
   function automatic logic [63:0] merge_bytes(
      input logic [63:0] old_word,
      input logic [63:0] new_word,
      input logic [7:0]  mask
   );
      logic [63:0] res;
      res = old_word;
      for (int b = 0; b < 8; b++) begin
         if (mask[b]) begin
            res[8*b +: 8] = new_word[8*b +: 8];
         end else begin
            res[8*b +: 8] = old_word[8*b +: 8];
         end
      end
      return res;
   endfunction

   logic [1:0]       state_r;
   logic [1:0]       state_nx_s;
   logic [3:0]       cnt_r;
   logic [3:0]       cnt_nx_s;
   logic             enter_resp_s;

   logic [IDX_W-1:0] lat_idx_r;
   logic             lat_wen_r;
   logic             lat_err_r;

   logic             req_ready_r;
   logic             resp_valid_r;
   logic [63:0]      resp_rdata_r;
   logic             resp_err_r;

   logic [63:0]      mem_r [DEPTH];

   logic [63:0]      off_s;
   logic [IDX_W-1:0] req_idx_s;
   logic             req_err_s;
   logic             accept_s;
   logic             commit_s;

   logic [IDX_W-1:0] cap_idx_s;
   logic             cap_wen_s;
   logic             cap_err_s;
   logic [63:0]      cap_rdata_s;

   // Word offset from BASE; the unsigned subtraction wraps for addresses below
   // BASE, so one compare against SPAN covers both ends of the window.
   assign off_s     = i_req_addr - BASE;
   assign req_idx_s = off_s[IDX_W+2:3];

`ifdef NPC_MEMRESP_BOUNDS_EN
   assign req_err_s = (off_s >= SPAN);
   logic unused_off_s;
   assign unused_off_s = ^off_s[2:0];
`else
   assign req_err_s = 1'b0;
   logic unused_off_s;
   assign unused_off_s = ^{off_s[63:IDX_W+3], off_s[2:0], SPAN};
`endif

   assign accept_s = (state_r == ST_IDLE) && req_ready_r && i_req_valid;
   // A write lands on the accept edge unless the address is out of bounds.
   assign commit_s = accept_s && i_req_wen && !req_err_s && !i_rst;

   // Next-state and latency-counter decode.
   always_comb begin
      state_nx_s   = state_r;
      cnt_nx_s     = cnt_r;
      enter_resp_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               cnt_nx_s = CNT_LOAD;
               if (LAT_ONE) begin
                  state_nx_s   = ST_RESP;
                  enter_resp_s = 1'b1;
               end else begin
                  state_nx_s   = ST_WAIT;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r <= 4'd1) begin
               cnt_nx_s     = 4'd0;
               state_nx_s   = ST_RESP;
               enter_resp_s = 1'b1;
            end else begin
               cnt_nx_s     = cnt_r - 4'd1;
               state_nx_s   = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (i_resp_ready) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_RESP;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = 4'd0;
         end
      endcase
   end

   // Select the request attributes used when the response is captured: with a
   // single-cycle latency the capture happens on the accept edge itself, so
   // the live request is used instead of the latched copy.
   always_comb begin
      if (state_r == ST_IDLE) begin
         cap_idx_s = req_idx_s;
         cap_wen_s = i_req_wen;
         cap_err_s = req_err_s;
      end else begin
         cap_idx_s = lat_idx_r;
         cap_wen_s = lat_wen_r;
         cap_err_s = lat_err_r;
      end
   end

   // Response data: write and error responses carry zero.
   always_comb begin
      if (cap_wen_s || cap_err_s) begin
         cap_rdata_s = 64'd0;
      end else begin
         cap_rdata_s = mem_r[cap_idx_s];
      end
   end

   // FSM state and latency counter.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
      end
   end

   // Latch the accepted request for the capture at the end of WAIT.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lat_idx_r <= {IDX_W{1'b0}};
         lat_wen_r <= 1'b0;
         lat_err_r <= 1'b0;
      end else if (accept_s) begin
         lat_idx_r <= req_idx_s;
         lat_wen_r <= i_req_wen;
         lat_err_r <= req_err_s;
      end else begin
         lat_idx_r <= lat_idx_r;
         lat_wen_r <= lat_wen_r;
         lat_err_r <= lat_err_r;
      end
   end

   // Registered handshake outputs derived from the next state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         req_ready_r  <= 1'b1;
         resp_valid_r <= 1'b0;
      end else begin
         req_ready_r  <= (state_nx_s == ST_IDLE);
         resp_valid_r <= (state_nx_s == ST_RESP);
      end
   end

   // Response payload: captured on the edge entering RESP and held after.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         resp_rdata_r <= 64'd0;
         resp_err_r   <= 1'b0;
      end else if (enter_resp_s) begin
         resp_rdata_r <= cap_rdata_s;
         resp_err_r   <= cap_err_s;
      end else begin
         resp_rdata_r <= resp_rdata_r;
         resp_err_r   <= resp_err_r;
      end
   end

   // Storage array; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (commit_s) begin
         mem_r[req_idx_s] <= merge_bytes(mem_r[req_idx_s], i_req_wdata, i_req_wmask);
      end
   end

   assign o_req_ready  = req_ready_r;
   assign o_resp_valid = resp_valid_r;
   assign o_resp_rdata = resp_rdata_r;
   assign o_resp_err   = resp_err_r;

endmodule

// File: tb/tb_ysyx_22050710_mem_responder.sv
// tb_ysyx_22050710_mem_responder
//   Two responders (LATENCY 2 and LATENCY 1) driven by request lists, checked
//   against a word-array reference model of the memory.
module tb_ysyx_22050710_mem_responder;

   localparam logic [63:0] BASE  = 64'h8000_0000;
   localparam int          DEPTH = 1024;

   typedef struct {
      logic [63:0] a;
      logic        w;
      logic [63:0] d;
      logic [7:0]  m;
      int          s;
   } req_t;

   logic        clk;
   logic        rst;
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic [63:0] req_addr   [2];
   logic        req_wen    [2];
   logic [63:0] req_wdata  [2];
   logic [7:0]  req_wmask  [2];
   logic        resp_valid [2];
   logic        resp_ready [2];
   logic [63:0] resp_rdata [2];
   logic        resp_err   [2];

   int          cyc;
   int          n_cmp;
   int          n_bad;

   logic [63:0] ref_mem [2][DEPTH];
   req_t        rq[$];
   logic [63:0] exp_d[$];
   logic        exp_e[$];
   int          exp_s[$];

   ysyx_22050710_mem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(2)) u_dut_l2 (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
      .i_req_addr(req_addr[0]), .i_req_wen(req_wen[0]),
      .i_req_wdata(req_wdata[0]), .i_req_wmask(req_wmask[0]),
      .o_resp_valid(resp_valid[0]), .i_resp_ready(resp_ready[0]),
      .o_resp_rdata(resp_rdata[0]), .o_resp_err(resp_err[0])
   );

   ysyx_22050710_mem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(1)) u_dut_l1 (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
      .i_req_addr(req_addr[1]), .i_req_wen(req_wen[1]),
      .i_req_wdata(req_wdata[1]), .i_req_wmask(req_wmask[1]),
      .o_resp_valid(resp_valid[1]), .i_resp_ready(resp_ready[1]),
      .o_resp_rdata(resp_rdata[1]), .o_resp_err(resp_err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: memory is an array of words; a request maps to word
   // ((addr - BASE) / 8) mod DEPTH, unless bounds checking rejects it.
   task automatic model(input int d, input req_t r, output logic [63:0] ed, output logic ee);
      int idx;
`ifdef NPC_MEMRESP_BOUNDS_EN
      ee = (r.a < BASE) || (r.a >= BASE + 64'(DEPTH) * 64'd8);
`else
      ee = 1'b0;
`endif
      ed = 64'd0;
      if (!ee) begin
         idx = int'(((r.a - BASE) / 64'd8) % 64'(DEPTH));
         if (r.w) begin
            for (int b = 0; b < 8; b++) begin
               if (r.m[b]) ref_mem[d][idx][8*b +: 8] = r.d[8*b +: 8];
            end
         end else begin
            ed = ref_mem[d][idx];
         end
      end
   endtask

   task automatic add(input logic [63:0] a, input logic w, input logic [63:0] dat,
                      input logic [7:0] m, input int s);
      req_t r;
      r.a = a; r.w = w; r.d = dat; r.m = m; r.s = s;
      rq.push_back(r);
   endtask

   task automatic add_random(input int win, input int n);
      logic [63:0] a;
      logic [7:0]  m;
      int          w;
      int          k;
      for (int i = 0; i < n; i++) begin
         w = int'($urandom_range(0, win - 1));
         k = int'($urandom_range(0, 9));
         if (k == 0)      a = BASE + 64'(DEPTH + w) * 64'd8;
         else if (k == 1) a = BASE - 64'(DEPTH - w) * 64'd8;
         else             a = BASE + 64'(w) * 64'd8 + 64'($urandom_range(0, 7));
         k = int'($urandom_range(0, 5));
         if (k == 0)      m = 8'h00;
         else if (k == 1) m = 8'hFF;
         else             m = 8'($urandom);
         add(a, 1'($urandom_range(0, 1)), {$urandom, $urandom}, m, int'($urandom_range(0, 3)));
      end
   endtask

   task automatic present_next(input int d);
      req_t        r;
      logic [63:0] ed;
      logic        ee;
      if (rq.size() > 0) begin
         r = rq.pop_front();
         req_addr[d]  = r.a;
         req_wen[d]   = r.w;
         req_wdata[d] = r.d;
         req_wmask[d] = r.m;
         req_valid[d] = 1'b1;
         model(d, r, ed, ee);
         exp_d.push_back(ed);
         exp_e.push_back(ee);
         exp_s.push_back(r.s);
      end else begin
         req_valid[d] = 1'b0;
         req_wen[d]   = 1'b0;
      end
   endtask

   // Run every queued request through responder d. The next request is put on
   // the bus as soon as the current response appears, so it waits through any
   // response stall and must be taken exactly one cycle after the handshake.
   task automatic run_q(input int d, input int lat);
      int n;
      int done;
      int guard;
      int stall_left;
      int acc_cyc;
      int hs_cyc;
      bit in_resp;
      bit have_hs;
      n = rq.size(); done = 0; guard = 0; stall_left = 0;
      acc_cyc = 0; hs_cyc = 0; in_resp = 1'b0; have_hs = 1'b0;
      @(negedge clk);
      present_next(d);
      while (done < n && guard < 60 * n + 60) begin
         if (resp_valid[d]) begin
            if (!in_resp) begin
               in_resp = 1'b1;
               check_eq("latency", 64'(cyc - acc_cyc), 64'(lat));
               stall_left = exp_s[0];
               present_next(d);
            end
            check_eq("rdata", resp_rdata[d], exp_d[0]);
            check_eq("err", 64'(resp_err[d]), 64'(exp_e[0]));
            check_eq("req_ready_in_resp", 64'(req_ready[d]), 64'd0);
            if (stall_left == 0) begin
               resp_ready[d] = 1'b1;
               in_resp = 1'b0;
               done++;
               void'(exp_d.pop_front());
               void'(exp_e.pop_front());
               void'(exp_s.pop_front());
               have_hs = 1'b1;
               hs_cyc = cyc;
            end else begin
               resp_ready[d] = 1'b0;
               stall_left--;
            end
         end else begin
            resp_ready[d] = 1'($urandom_range(0, 1));
            if (req_valid[d] && req_ready[d]) begin
               acc_cyc = cyc;
               if (have_hs) check_eq("issue_gap", 64'(cyc - hs_cyc), 64'd1);
               have_hs = 1'b0;
            end
         end
         @(negedge clk);
         guard++;
      end
      if (done < n) check_eq("timeout_done", 64'(done), 64'(n));
      check_eq("idle_valid", 64'(resp_valid[d]), 64'd0);
      check_eq("idle_ready", 64'(req_ready[d]), 64'd1);
      resp_ready[d] = 1'b0;
      rq.delete(); exp_d.delete(); exp_e.delete(); exp_s.delete();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      req_t        rr;
      logic [63:0] ed;
      logic        ee;
      cyc = 0; n_cmp = 0; n_bad = 0; rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0; req_addr[d] = 64'd0; req_wen[d] = 1'b0;
         req_wdata[d] = 64'd0; req_wmask[d] = 8'd0; resp_ready[d] = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check_eq("rst_req_ready", 64'(req_ready[d]), 64'd1);
         check_eq("rst_resp_valid", 64'(resp_valid[d]), 64'd0);
         check_eq("rst_rdata", resp_rdata[d], 64'd0);
         check_eq("rst_err", 64'(resp_err[d]), 64'd0);
      end
      rst = 1'b0;

      // LATENCY 2: fill words 0..15, then the directed sequence.
      for (int w = 0; w < 16; w++) add(BASE + 64'(w) * 64'd8, 1'b1, {$urandom, $urandom}, 8'hFF, 0);
      run_q(0, 2);
      add(64'h8000_0010, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 0);
      add(64'h8000_0010, 1'b0, 64'd0, 8'h00, 0);
      add(64'h8000_0010, 1'b1, 64'hFFFF_FFFF_AAAA_BBBB, 8'h0F, 0);
      add(64'h8000_0010, 1'b0, 64'd0, 8'h00, 5);
      add(64'h8000_0018, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'h00, 1);
      add(64'h8000_0018, 1'b0, 64'd0, 8'h00, 0);
      add(64'h7FFF_FFF8, 1'b0, 64'd0, 8'h00, 0);
      add(64'h8000_2000, 1'b1, 64'h0BAD_F00D_CAFE_0123, 8'hFF, 2);
      add(64'h8000_0000, 1'b0, 64'd0, 8'h00, 0);
      run_q(0, 2);
      add_random(16, 60);
      run_q(0, 2);

      // Reset while a write is waiting: no response, but the write sticks.
      @(negedge clk);
      rr.a = BASE + 64'h28; rr.w = 1'b1; rr.d = {$urandom, $urandom}; rr.m = 8'hFF; rr.s = 0;
      req_addr[0] = rr.a; req_wen[0] = 1'b1; req_wdata[0] = rr.d; req_wmask[0] = rr.m;
      req_valid[0] = 1'b1;
      model(0, rr, ed, ee);
      @(negedge clk);
      req_valid[0] = 1'b0; req_wen[0] = 1'b0;
      check_eq("wait_req_ready", 64'(req_ready[0]), 64'd0);
      check_eq("wait_resp_valid", 64'(resp_valid[0]), 64'd0);
      rst = 1'b1;
      #1;
      check_eq("midrst_req_ready", 64'(req_ready[0]), 64'd1);
      check_eq("midrst_resp_valid", 64'(resp_valid[0]), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_eq("no_stale_resp", 64'(resp_valid[0]), 64'd0);
      end
      add(BASE + 64'h28, 1'b0, 64'd0, 8'h00, 0);
      run_q(0, 2);

      // LATENCY 1: fill, back-to-back reads with ready held, then random.
      for (int w = 0; w < 8; w++) add(BASE + 64'(w) * 64'd8, 1'b1, {$urandom, $urandom}, 8'hFF, 0);
      for (int w = 0; w < 6; w++) add(BASE + 64'(w) * 64'd8, 1'b0, 64'd0, 8'h00, 0);
      run_q(1, 1);
      add_random(8, 40);
      run_q(1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
